// File: rtl/sfr_file_pkg.sv
// Shared definitions for the SFR file: register map, status-register layout,
// stack-pointer reset value and the timer prescale decode.
package sfr_file_pkg;

    localparam logic [2:0] SFR_SR   = 3'd0;
    localparam logic [2:0] SFR_SP   = 3'd1;
    localparam logic [2:0] SFR_TMR  = 3'd2;
    localparam logic [2:0] SFR_TCTL = 3'd3;

    // SR layout: [3:0] = {V,N,C,Z}, [6:4] software bits, [7] sticky timer overflow
    localparam int SR_FLAGS_MSB = 3;
    localparam int SR_IRQ       = 7;

    localparam int TCTL_EN = 0;

    localparam logic [7:0] SP_RESET = 8'hFF;

    // Terminal prescaler count: one timer tick every 1, 2, 4 or 8 cycles
    function automatic logic [2:0] prescale_limit(input logic [1:0] sel);
        case (sel)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/sfr_timer.sv
// Timer engine: prescaler, TMR increment value and the overflow pulse that
// sets the sticky SR overflow bit.
module sfr_timer
    import sfr_file_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [2:0]            tctl,
    input  logic                  tctl_wr,
    input  logic                  tmr_wr,
    input  logic [DATA_WIDTH-1:0] tmr,
    output logic                  tick,
    output logic [DATA_WIDTH-1:0] tmr_inc,
    output logic                  ovf
);

    logic [2:0] prescaler;
    logic [2:0] limit;

    assign limit   = prescale_limit(tctl[2:1]);
    assign tick    = tctl[TCTL_EN] && (prescaler == limit);
    assign tmr_inc = tmr + DATA_WIDTH'(1);
    // A same-cycle TMR write replaces the wrap, so it must not raise overflow
    assign ovf     = tick && !tmr_wr && (&tmr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= 3'd0;
        end else if (!tctl[TCTL_EN] || tctl_wr || (prescaler == limit)) begin
            prescaler <= 3'd0;
        end else begin
            prescaler <= prescaler + 3'd1;
        end
    end

endmodule

// File: rtl/sfr_file.sv
// Special function register file: status, stack pointer, timer and GP registers
// with explicit writes taking priority over implicit hardware updates.
module sfr_file
    import sfr_file_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SFR    = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [2:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flag_wr_en,
    input  logic [3:0]            flags_in,
    input  logic                  sp_push,
    input  logic                  sp_pop,
    output logic [DATA_WIDTH-1:0] sp_out,
    output logic                  tmr_irq
);

    logic [DATA_WIDTH-1:0] regs      [NUM_SFR];
    logic [DATA_WIDTH-1:0] next_regs [NUM_SFR];

    logic                  tmr_tick;
    logic                  tmr_ovf;
    logic [DATA_WIDTH-1:0] tmr_inc;
    logic                  tctl_wr;
    logic                  tmr_wr;

    assign tctl_wr = wr_en && (wr_addr == SFR_TCTL);
    assign tmr_wr  = wr_en && (wr_addr == SFR_TMR);

    sfr_timer #(.DATA_WIDTH(DATA_WIDTH)) timer (
        .clock   (clock),
        .reset_n (reset_n),
        .tctl    (regs[SFR_TCTL][2:0]),
        .tctl_wr (tctl_wr),
        .tmr_wr  (tmr_wr),
        .tmr     (regs[SFR_TMR]),
        .tick    (tmr_tick),
        .tmr_inc (tmr_inc),
        .ovf     (tmr_ovf)
    );

    // Implicit updates first, explicit write last so it overrides them
    always_comb begin
        next_regs = regs;
        if (flag_wr_en) next_regs[SFR_SR][SR_FLAGS_MSB:0] = flags_in;
        if (tmr_ovf)    next_regs[SFR_SR][SR_IRQ] = 1'b1;
        if (sp_push && !sp_pop) begin
            next_regs[SFR_SP] = regs[SFR_SP] - DATA_WIDTH'(1);
        end else if (sp_pop && !sp_push) begin
            next_regs[SFR_SP] = regs[SFR_SP] + DATA_WIDTH'(1);
        end
        if (tmr_tick) next_regs[SFR_TMR] = tmr_inc;
        if (wr_en) begin
            next_regs[wr_addr] = wr_data;
            // Overflow is never lost to a concurrent SR write
            if ((wr_addr == SFR_SR) && tmr_ovf) next_regs[SFR_SR][SR_IRQ] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SFR; i++) regs[i] <= '0;
            regs[SFR_SP] <= DATA_WIDTH'(SP_RESET);
        end else begin
            regs <= next_regs;
        end
    end

    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : regs[rd_addr];
    assign sp_out  = regs[SFR_SP];
    assign tmr_irq = regs[SFR_SR][SR_IRQ];

endmodule

// File: tb/tb_sfr_file.sv
// Directed bench for sfr_file: expectations are queued as stimulus is applied
// and popped when the corresponding output is sampled.
module tb_sfr_file;
    import sfr_file_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       flag_wr_en;
    logic [3:0] flags_in;
    logic       sp_push;
    logic       sp_pop;
    logic [7:0] sp_out;
    logic       tmr_irq;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    sfr_file #(.DATA_WIDTH(8), .NUM_SFR(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .flag_wr_en (flag_wr_en),
        .flags_in   (flags_in),
        .sp_push    (sp_push),
        .sp_pop     (sp_pop),
        .sp_out     (sp_out),
        .tmr_irq    (tmr_irq)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_val(input logic [7:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%02h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic read_chk(input logic [2:0] a, input logic [7:0] v, input string tag);
        rd_addr = a;
        push_exp(tag, v);
        #1;
        check_val(rd_data);
    endtask

    task automatic irq_chk(input logic v, input string tag);
        push_exp(tag, {7'd0, v});
        check_val({7'd0, tmr_irq});
    endtask

    task automatic sp_chk(input logic [7:0] v, input string tag);
        push_exp(tag, v);
        check_val(sp_out);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 8'h00;
        rd_addr    = 3'd0;
        flag_wr_en = 1'b0;
        flags_in   = 4'h0;
        sp_push    = 1'b0;
        sp_pop     = 1'b0;

        // reset contents visible while reset is held
        #2 reset_n = 1'b0;
        #1;
        for (int a = 0; a < 8; a++)
            read_chk(3'(a), (a == 1) ? 8'hFF : 8'h00, $sformatf("reset_rd%0d", a));
        sp_chk(8'hFF, "reset_sp_out");
        irq_chk(1'b0, "reset_irq");

        step();
        step();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++)
            read_chk(3'(a), (a == 1) ? 8'hFF : 8'h00, $sformatf("post_reset_rd%0d", a));

        // write bypass
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_data = 8'hA5;
        read_chk(3'd5, 8'hA5, "bypass_same_cycle");
        read_chk(3'd4, 8'h00, "bypass_other_addr");
        step();
        wr_en = 1'b0;
        read_chk(3'd5, 8'hA5, "bypass_held");

        // stack pointer
        wr_en   = 1'b1;
        wr_addr = SFR_SP;
        wr_data = 8'h00;
        #1;
        sp_chk(8'hFF, "sp_out_no_bypass");
        step();
        wr_en = 1'b0;
        sp_chk(8'h00, "sp_written");
        sp_push = 1'b1;
        step();
        sp_push = 1'b0;
        sp_chk(8'hFF, "sp_push_wrap");
        sp_pop = 1'b1;
        step();
        sp_pop = 1'b0;
        sp_chk(8'h00, "sp_pop_wrap");
        sp_push = 1'b1;
        sp_pop  = 1'b1;
        step();
        sp_push = 1'b0;
        sp_pop  = 1'b0;
        sp_chk(8'h00, "sp_push_pop");
        sp_push = 1'b1;
        wr(SFR_SP, 8'h40);
        sp_push = 1'b0;
        sp_chk(8'h40, "sp_write_beats_push");

        // status flags
        flag_wr_en = 1'b1;
        flags_in   = 4'hA;
        step();
        flag_wr_en = 1'b0;
        read_chk(SFR_SR, 8'h0A, "sr_flags");
        flag_wr_en = 1'b1;
        flags_in   = 4'hA;
        wr(SFR_SR, 8'h05);
        flag_wr_en = 1'b0;
        read_chk(SFR_SR, 8'h05, "sr_write_beats_flags");
        wr(SFR_SR, 8'h70);
        flag_wr_en = 1'b1;
        flags_in   = 4'h3;
        step();
        flag_wr_en = 1'b0;
        read_chk(SFR_SR, 8'h73, "sr_flags_keep_sw_bits");
        wr(SFR_SR, 8'h00);

        // timer overflow with prescale 2
        wr(SFR_TMR, 8'hFE);
        read_chk(SFR_TMR, 8'hFE, "tmr_loaded");
        wr(SFR_TCTL, 8'h03);
        read_chk(SFR_TCTL, 8'h03, "tctl_loaded");
        step();
        read_chk(SFR_TMR, 8'hFE, "tmr_cycle1");
        step();
        read_chk(SFR_TMR, 8'hFF, "tmr_cycle2");
        irq_chk(1'b0, "irq_before_wrap");
        step();
        read_chk(SFR_TMR, 8'hFF, "tmr_cycle3");
        step();
        read_chk(SFR_TMR, 8'h00, "tmr_cycle4_wrap");
        irq_chk(1'b1, "irq_on_wrap");
        step();
        irq_chk(1'b1, "irq_sticky1");
        step();
        irq_chk(1'b1, "irq_sticky2");
        read_chk(SFR_TMR, 8'h01, "tmr_after_wrap");
        wr(SFR_SR, 8'h00);
        irq_chk(1'b0, "irq_cleared");

        // overflow collisions at prescale 1
        wr(SFR_TCTL, 8'h01);
        wr(SFR_TMR, 8'hFF);
        read_chk(SFR_TMR, 8'hFF, "tmr_write_beats_inc");
        irq_chk(1'b0, "tmr_write_no_ovf");
        flag_wr_en = 1'b1;
        flags_in   = 4'hA;
        wr(SFR_SR, 8'h05);
        flag_wr_en = 1'b0;
        read_chk(SFR_SR, 8'h85, "sr_write_with_ovf");
        irq_chk(1'b1, "irq_with_sr_write");

        // asynchronous reset in the middle of counting
        wr(SFR_TCTL, 8'h07);
        wr(3'd6, 8'h3C);
        step();
        step();
        #3 reset_n = 1'b0;
        #1;
        for (int a = 0; a < 8; a++)
            read_chk(3'(a), (a == 1) ? 8'hFF : 8'h00, $sformatf("midreset_rd%0d", a));
        sp_chk(8'hFF, "midreset_sp_out");
        irq_chk(1'b0, "midreset_irq");
        step();
        reset_n = 1'b1;
        step();
        step();
        read_chk(SFR_TMR, 8'h00, "tmr_idle_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
